// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and the fetch-buffer entry layout for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: entries are allocated at issue, filled by responses in order, popped at head.
// Head is read straight from the entry flops; clear drops every entry in one cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_alloc,
  input  logic [XLEN-1:0]  i_alloc_pc,
  input  logic             i_fill,
  input  logic [ILEN-1:0]  i_fill_instr,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [CW-1:0]    o_count,
  output logic [CW-1:0]    o_unfilled,
  output fetch_entry_t     o_head
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_fill;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_unfilled;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i].pc     <= RESET_PC;
        r_mem[i].instr  <= '0;
        r_mem[i].filled <= 1'b0;
      end
      r_wr       <= '0;
      r_fill     <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
    end else if (i_clear) begin
      // pc/instr are left as-is; only the filled flags matter once pointers reset
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i].filled <= 1'b0;
      end
      r_wr       <= '0;
      r_fill     <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
    end else begin
      if (i_pop) begin
        r_mem[r_rd].filled <= 1'b0;
        r_rd               <= r_rd + 1'b1;
      end
      if (i_fill) begin
        r_mem[r_fill].instr  <= i_fill_instr;
        r_mem[r_fill].filled <= 1'b1;
        r_fill               <= r_fill + 1'b1;
      end
      if (i_alloc) begin
        r_mem[r_wr].pc     <= i_alloc_pc;
        r_mem[r_wr].filled <= 1'b0;
        r_wr               <= r_wr + 1'b1;
      end
      r_count    <= r_count + CW'(i_alloc) - CW'(i_pop);
      r_unfilled <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
    end
  end

  assign o_count    = r_count;
  assign o_unfilled = r_unfilled;
  assign o_head     = r_mem[r_rd];

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: issues PC to instruction memory, buffers in-order returns, hands them to decode.
// Decode sees an instruction memory-latency+1 cycles after issue; a full buffer stalls the PC.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  PC_Value,
  input  logic             flush,
  output logic             pc_stall,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [ILEN-1:0]  imem_rsp_data,
  input  logic             id_ready,
  output logic             if_valid,
  output logic [ILEN-1:0]  if_instr,
  output logic [XLEN-1:0]  if_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]  w_count;
  logic [CW-1:0]  w_unfilled;
  fetch_entry_t   w_head;
  logic           w_pop;
  logic           w_req_vld;
  logic           w_issue;
  logic           w_drop;
  logic           w_kept;
  logic           w_fill;
  logic [CW-1:0]  r_drop_cnt;

  assign w_pop     = w_head.filled & id_ready & ~flush;
  assign w_req_vld = rst & ~flush & ((w_count < CW'(DEPTH)) | w_pop);
  assign w_issue   = w_req_vld & imem_req_ready;

  // Responses for wrong-path requests are still owed by memory; they are swallowed here
  assign w_drop = imem_rsp_valid & (r_drop_cnt != '0);
  assign w_kept = imem_rsp_valid & ~w_drop & (w_unfilled != '0);
  assign w_fill = w_kept & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (flush) begin
      r_drop_cnt <= r_drop_cnt - CW'(w_drop) + w_unfilled - CW'(w_kept);
    end else if (w_drop) begin
      r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .i_alloc      (w_issue),
    .i_alloc_pc   (PC_Value),
    .i_fill       (w_fill),
    .i_fill_instr (imem_rsp_data),
    .i_pop        (w_pop),
    .i_clear      (flush),
    .o_count      (w_count),
    .o_unfilled   (w_unfilled),
    .o_head       (w_head)
  );

  assign imem_req_valid = w_req_vld;
  assign imem_req_addr  = PC_Value;
  assign pc_stall       = ~flush & ~w_issue;
  assign if_valid       = w_head.filled;
  assign if_instr       = w_head.instr;
  assign if_pc          = w_head.pc;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench: program counter, fixed-latency memory and a queue-based model of the fetch stage.
module tb_instr_fetch_stage;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [XLEN-1:0]  PC_Value = '0;
  logic             flush = 1'b0;
  logic             pc_stall;
  logic             imem_req_valid;
  logic             imem_req_ready = 1'b0;
  logic [XLEN-1:0]  imem_req_addr;
  logic             imem_rsp_valid;
  logic [ILEN-1:0]  imem_rsp_data;
  logic             id_ready = 1'b0;
  logic             if_valid;
  logic [ILEN-1:0]  if_instr;
  logic [XLEN-1:0]  if_pc;

  always #5 clk = ~clk;

  instr_fetch_stage #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .PC_Value       (PC_Value),
    .flush          (flush),
    .pc_stall       (pc_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Memory: a request accepted at edge k returns during cycle k+lat
  logic [3:0]   pipe_v;
  logic [31:0]  pipe_a [4];
  logic [1:0]   lat_idx;
  assign imem_rsp_valid = pipe_v[lat_idx];
  assign imem_rsp_data  = mem_word(pipe_a[lat_idx]);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } live_t;
  typedef struct {
    logic [31:0] pc;
    int          gen;
  } req_t;

  live_t live[$];
  req_t  outq[$];
  int    gen;
  int    n_cmp;
  int    n_bad;
  int    p_rdy;
  int    p_mrdy;
  int    p_flush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    bit          e_valid;
    bit          e_pop;
    bit          e_req;
    bit          e_issue;
    bit          e_stall;
    bit          mem_issue;
    logic [31:0] mem_addr;
    logic [31:0] tgt;
    logic [31:0] pc_nxt;
    req_t        r;

    @(negedge clk);
    flush          = ($urandom_range(99) < p_flush);
    id_ready       = ($urandom_range(99) < p_rdy);
    imem_req_ready = ($urandom_range(99) < p_mrdy);
    tgt            = 32'h100 + ($urandom_range(63) << 2);
    #1;

    e_valid = (live.size() > 0) && live[0].filled;
    e_pop   = e_valid && id_ready && !flush;
    e_req   = !flush && ((live.size() < DEPTH) || e_pop);
    e_issue = e_req && imem_req_ready;
    e_stall = !flush && !e_issue;

    chk("if_valid", 32'(if_valid), 32'(e_valid));
    if (e_valid) begin
      chk("if_pc", if_pc, live[0].pc);
      chk("if_instr", if_instr, live[0].instr);
    end
    chk("req_valid", 32'(imem_req_valid), 32'(e_req));
    if (e_req) chk("req_addr", imem_req_addr, PC_Value);
    chk("pc_stall", 32'(pc_stall), 32'(e_stall));

    mem_issue = imem_req_valid && imem_req_ready;
    mem_addr  = imem_req_addr;

    if (imem_rsp_valid && outq.size() > 0) begin
      r = outq.pop_front();
      if (!flush && r.gen == gen) begin
        for (int i = 0; i < live.size(); i++) begin
          if (!live[i].filled) begin
            live[i].filled = 1'b1;
            live[i].instr  = mem_word(r.pc);
            break;
          end
        end
      end
    end
    if (e_pop) void'(live.pop_front());
    if (e_issue) begin
      live.push_back('{pc: PC_Value, instr: 32'h0, filled: 1'b0});
      outq.push_back('{pc: PC_Value, gen: gen});
    end
    if (flush) begin
      live.delete();
      gen++;
    end
    pc_nxt = flush ? tgt : (e_stall ? PC_Value : PC_Value + 32'd4);

    @(posedge clk);
    #1;
    PC_Value = pc_nxt;
    for (int i = 3; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = mem_issue;
    pipe_a[0] = mem_addr;
  endtask

  task automatic do_reset(input int lat);
    @(negedge clk);
    #3;
    rst            = 1'b0;
    flush          = 1'b0;
    id_ready       = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_pc_stall", 32'(pc_stall), 32'h1);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    pipe_v = '0;
    for (int i = 0; i < 4; i++) pipe_a[i] = '0;
    lat_idx = 2'(lat - 1);
    live.delete();
    outq.delete();
    PC_Value = RESET_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_req_valid", 32'(imem_req_valid), 32'h1);
    chk("rel_req_addr", imem_req_addr, 32'h0);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    gen     = 0;
    pipe_v  = '0;
    lat_idx = 2'd0;
    for (int i = 0; i < 4; i++) pipe_a[i] = '0;

    // 1-cycle memory: streaming, decode backpressure, memory backpressure
    do_reset(1);
    p_rdy = 100; p_mrdy = 100; p_flush = 0;
    repeat (30) step();
    p_rdy = 0;
    repeat (6) step();
    p_rdy = 100;
    repeat (10) step();
    p_mrdy = 0;
    repeat (5) step();
    p_mrdy = 100;
    repeat (8) step();
    p_rdy = 70; p_mrdy = 80; p_flush = 10;
    repeat (300) step();

    // 3-cycle memory, reset mid-stream: flush with requests in flight, then random
    do_reset(3);
    p_rdy = 100; p_mrdy = 100; p_flush = 0;
    repeat (4) step();
    p_flush = 100;
    step();
    p_flush = 0;
    repeat (12) step();
    p_rdy = 60; p_mrdy = 75; p_flush = 12;
    repeat (500) step();

    // 2-cycle memory with heavier decode stalls
    do_reset(2);
    p_rdy = 40; p_mrdy = 90; p_flush = 8;
    repeat (400) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
